// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit little-endian words for the instruction
// memory and holds the core in reset until a full image has loaded. Macro: CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
`ifdef CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } wr_t;

    // State entered once the data section (or an empty header) completes.
`ifdef CHECKSUM_EN
    localparam state_e ST_TAIL = ST_CSUM;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

    state_e              state_q, state_d;
    logic [7:0]          hdr_lo_q;
    logic [16:0]         words_left_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [23:0]         wbuf_q;
    wr_t                 wr_q;
    logic                s_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                core_rst_q;

    logic                xfer;
    logic                start_load;
    logic [15:0]         hdr_n;
    logic                hdr_too_big;
    logic                word_done;
    logic                nxt_busy;

    assign xfer        = s_valid && s_ready_q;
    assign start_load  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign hdr_n       = {s_data, hdr_lo_q};
    assign hdr_too_big = {1'b0, hdr_n} > CAP;
    assign word_done   = xfer && (state_q == ST_DATA) && (byte_idx_q == 2'd3);

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    assign sum_d = sum_q + s_data;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_HDR0;
            end
            ST_HDR0: begin
                if (xfer) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                if (xfer) begin
                    if (hdr_n == 16'd0)   state_d = ST_TAIL;
                    else if (hdr_too_big) state_d = ST_ERR;
                    else                  state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done && words_left_q == 17'd1) state_d = ST_TAIL;
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) state_d = (sum_d == 8'd0) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign nxt_busy = (state_d == ST_HDR0) || (state_d == ST_HDR1) ||
`ifdef CHECKSUM_EN
                      (state_d == ST_CSUM) ||
`endif
                      (state_d == ST_DATA);

    // Status outputs are decoded from the next state so they are registered
    // and line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hdr_lo_q     <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            wbuf_q       <= '0;
            wr_q         <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_ready_q  <= nxt_busy;
            busy_q     <= nxt_busy;
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERR);
            core_rst_q <= (state_d == ST_DONE);
            wr_q.we    <= 1'b0;

            if (start_load) begin
                word_idx_q   <= '0;
                byte_idx_q   <= '0;
                words_left_q <= '0;
`ifdef CHECKSUM_EN
                sum_q        <= '0;
`endif
            end

            if (xfer) begin
`ifdef CHECKSUM_EN
                sum_q <= sum_d;
`endif
                case (state_q)
                    ST_HDR0: hdr_lo_q     <= s_data;
                    ST_HDR1: words_left_q <= {1'b0, hdr_n};
                    ST_DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: wbuf_q[7:0]   <= s_data;
                            2'd1: wbuf_q[15:8]  <= s_data;
                            2'd2: wbuf_q[23:16] <= s_data;
                            default: begin
                                wr_q.we      <= 1'b1;
                                wr_q.addr    <= 32'({word_idx_q, 2'b00});
                                wr_q.wdata   <= {s_data, wbuf_q};
                                word_idx_q   <= word_idx_q + 1'b1;
                                words_left_q <= words_left_q - 17'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = wr_q.we;
    assign mem_addr  = wr_q.addr;
    assign mem_wdata = wr_q.wdata;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
